uart_loader: RTL and testbench
==============================

// Module: uart_loader
// PURPOSE
//  Byte-stream packet loader sitting directly downstream of the UART receiver. Consumes received
//  bytes over a valid/ready handshake, parses a framed load packet (sync, address, length, data,
//  checksum), assembles little-endian 32-bit words and issues them as memory writes (e.g. IMEM/DMEM
//  preload) over a valid/ready write port. Reports packet completion, checksum status and timeouts.
// PARAMETERS
//  SYNC_BYTE       8'hA5      start-of-packet marker; other bytes in IDLE are consumed and dropped
//  TIMEOUT_CYCLES  1_250_000  max clk cycles between accepted bytes inside a packet (10 ms @125 MHz)
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high reset
//  data_in        in   8   byte from UART receiver
//  data_in_valid  in   1   data_in holds a byte
//  data_in_ready  out  1   loader accepts byte this cycle (transfer = valid && ready)
//  wr_addr        out  32  word write address (bits [1:0] always 0)
//  wr_data        out  32  word write data
//  wr_valid       out  1   write request pending
//  wr_ready       in   1   memory accepts write (transfer = wr_valid && wr_ready)
//  busy           out  1   1 whenever state != IDLE
//  pkt_done       out  1   1-cycle pulse: checksum byte accepted
//  pkt_ok         out  1   checksum result of last completed packet; valid from pkt_done onward
//  err_timeout    out  1   1-cycle pulse: packet aborted by timeout
// BEHAVIOUR
//  Packet: SYNC | ADDR b0..b3 (LE) | LEN (words, 0..255) | LEN*4 data bytes (LE) | CSUM.
//  Checksum: 8-bit sum of ADDR, LEN, data and CSUM bytes == 8'h00 -> pkt_ok=1, else 0.
//  Reset: state=IDLE; data_in_ready=1; wr_valid=0; wr_addr=0; wr_data=0; busy=0; pkt_done=0;
//   pkt_ok=0; err_timeout=0. Reset mid-packet aborts: partial word dropped, no write, no pulses.
//  States: IDLE -(SYNC accepted)-> ADDR -(4th byte)-> LEN -(LEN==0)-> CSUM | -(LEN>0)-> DATA
//   DATA -(4th byte of word)-> WRITE -(wr handshake, words left)-> DATA | -(last word)-> CSUM
//   CSUM -(byte accepted)-> IDLE with pkt_done pulse and pkt_ok updated the next cycle.
//  data_in_ready = 1 in every state except WRITE (0 there); upstream holds bytes meanwhile.
//  Write latency: 4th data byte accepted in cycle N -> wr_valid=1 in cycle N+1.
//  wr_addr/wr_data stable while wr_valid && !wr_ready; wr_valid drops the cycle after handshake.
//  First write at {ADDR[31:2],2'b00}; each next word +4; address wraps modulo 2^32.
//  Writes occur before checksum is known; bad checksum only clears pkt_ok (no rollback).
//  Timeout counter: cleared on every accepted byte and in IDLE/WRITE; counts in ADDR/LEN/DATA/CSUM.
//   Reaching TIMEOUT_CYCLES -> IDLE next cycle, err_timeout pulse, pkt_done not asserted.
//  Counter widths: byte index 2 bits, word count 8 bits, timeout $clog2(TIMEOUT_CYCLES+1) bits.
// TESTING
//  1 A5 00 10 00 00 02 78 56 34 12 EF BE AD DE A2 -> writes (0x1000,0x12345678),
//    (0x1004,0xDEADBEEF); pkt_done pulse; pkt_ok=1; busy=0 after.
//  2 Same packet with CSUM 0x00 -> same two writes; pkt_done pulse; pkt_ok=0.
//  3 Case 1 with wr_ready=0 for 20 cycles on first write -> wr_valid/addr/data held 20 cycles,
//    data_in_ready=0 throughout, no byte lost; both writes correct.
//  4 00 FF 3C then case 1 -> leading bytes consumed (ready=1), ignored; result as case 1.
//  5 TIMEOUT_CYCLES=100: A5 00 10 then silence -> err_timeout pulse 100 cycles after last byte,
//    busy=0, no write, no pkt_done; following valid packet loads normally.
//  6 A5 03 00 00 00 00 FD (LEN=0) -> no writes; pkt_done with pkt_ok=1. Also reset mid-DATA
//    -> IDLE next cycle, wr_valid stays 0.

Source files
------------

// File: rtl/uart_loader.sv
// UART byte-stream packet loader: parses SYNC/ADDR/LEN/DATA/CSUM frames
// and issues little-endian 32-bit word writes over a valid/ready port.
module uart_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_250_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        data_in_valid,
  output logic        data_in_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        busy,
  output logic        pkt_done,
  output logic        pkt_ok,
  output logic        err_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_LEN   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;

  logic [2:0]    state;
  logic [1:0]    idx;
  logic [7:0]    words;
  logic [23:0]   buf_q;
  logic [31:0]   addr;
  logic [7:0]    csum;
  logic [TW-1:0] tmo;
  logic          accept;
  logic          counting;
  logic          tmo_hit;

  assign data_in_ready = (state != S_WRITE);
  assign busy          = (state != S_IDLE);
  assign accept        = data_in_valid && data_in_ready;
  assign counting      = (state == S_ADDR) || (state == S_LEN) ||
                         (state == S_DATA) || (state == S_CSUM);
  // Fires on the last silent cycle so the abort lands TIMEOUT_CYCLES later
  assign tmo_hit       = counting && !accept && (tmo == TLAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= 2'd0;
      words       <= 8'd0;
      buf_q       <= 24'd0;
      addr        <= 32'd0;
      csum        <= 8'd0;
      tmo         <= '0;
      wr_addr     <= 32'd0;
      wr_data     <= 32'd0;
      wr_valid    <= 1'b0;
      pkt_done    <= 1'b0;
      pkt_ok      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      pkt_done    <= 1'b0;
      err_timeout <= 1'b0;
      if (!counting || accept) tmo <= '0;
      else                     tmo <= tmo + 1'b1;
      if (tmo_hit) begin
        state       <= S_IDLE;
        err_timeout <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept && data_in == SYNC_BYTE) begin
              state <= S_ADDR;
              idx   <= 2'd0;
              csum  <= 8'd0;
            end
          end
          S_ADDR: begin
            if (accept) begin
              addr <= {data_in, addr[31:8]};
              csum <= csum + data_in;
              idx  <= idx + 2'd1;
              if (idx == 2'd3) state <= S_LEN;
            end
          end
          S_LEN: begin
            if (accept) begin
              words <= data_in;
              csum  <= csum + data_in;
              idx   <= 2'd0;
              state <= (data_in == 8'd0) ? S_CSUM : S_DATA;
            end
          end
          S_DATA: begin
            if (accept) begin
              buf_q <= {data_in, buf_q[23:8]};
              csum  <= csum + data_in;
              idx   <= idx + 2'd1;
              if (idx == 2'd3) begin
                wr_addr  <= {addr[31:2], 2'b00};
                wr_data  <= {data_in, buf_q};
                wr_valid <= 1'b1;
                state    <= S_WRITE;
              end
            end
          end
          S_WRITE: begin
            if (wr_ready) begin
              wr_valid <= 1'b0;
              addr     <= addr + 32'd4;
              words    <= words - 8'd1;
              state    <= (words == 8'd1) ? S_CSUM : S_DATA;
            end
          end
          S_CSUM: begin
            if (accept) begin
              pkt_done <= 1'b1;
              pkt_ok   <= ((csum + data_in) == 8'h00);
              state    <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: table of packets plus stall,
// timeout and mid-packet reset sequences.
module tb_uart_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        data_in_valid = 1'b0;
  logic        data_in_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic        busy;
  logic        pkt_done;
  logic        pkt_ok;
  logic        err_timeout;

  uart_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .busy(busy), .pkt_done(pkt_done), .pkt_ok(pkt_ok),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [159:0] bytes;
    int           n;
    int           nwr;
    logic [31:0]  a0, d0, a1, d1;
    logic         ok;
  } vec_t;

  vec_t        v[4];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_done = 0;
  int          n_tmo = 0;
  int          tmo_cyc = 0;
  int          last_acc = 0;
  logic [63:0] obs[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_valid && wr_ready) obs.push_back({wr_addr, wr_data});
    if (pkt_done) n_done++;
    if (err_timeout) begin
      n_tmo++;
      tmo_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bit got = 0;
    @(posedge clk); #1;
    data_in = b;
    data_in_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      if (data_in_ready) got = 1;
      else n++;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL send_byte: ready=0 after %0d cycles, want 1", n);
    end else begin
      last_acc = cyc;
      @(posedge clk); #1;
    end
    data_in_valid = 1'b0;
  endtask

  task automatic clear_obs();
    obs.delete();
    n_done = 0;
    n_tmo = 0;
  endtask

  task automatic check_pkt(input int i, input string tag);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, " nwr"}, obs.size(), v[i].nwr);
    if (v[i].nwr > 0 && obs.size() > 0)
      chk({tag, " wr0"}, obs[0], {v[i].a0, v[i].d0});
    if (v[i].nwr > 1 && obs.size() > 1)
      chk({tag, " wr1"}, obs[1], {v[i].a1, v[i].d1});
    chk({tag, " done"}, n_done, 1);
    chk({tag, " ok"}, pkt_ok, v[i].ok);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " tmo"}, n_tmo, 0);
  endtask

  task automatic run_vec(input int i);
    clear_obs();
    for (int j = 0; j < v[i].n; j++)
      send_byte(v[i].bytes[159 - 8*j -: 8]);
    check_pkt(i, $sformatf("vec%0d", i));
  endtask

  initial begin
    v[0] = '{{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02,
              8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE,
              8'hAD, 8'hDE, 8'hA2, 40'h0},
             15, 2, 32'h1000, 32'h12345678,
             32'h1004, 32'hDEADBEEF, 1'b1};
    v[1] = '{{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02,
              8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE,
              8'hAD, 8'hDE, 8'h00, 40'h0},
             15, 2, 32'h1000, 32'h12345678,
             32'h1004, 32'hDEADBEEF, 1'b0};
    v[2] = '{{8'h00, 8'hFF, 8'h3C,
              8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02,
              8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE,
              8'hAD, 8'hDE, 8'hA2, 16'h0},
             18, 2, 32'h1000, 32'h12345678,
             32'h1004, 32'hDEADBEEF, 1'b1};
    v[3] = '{{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00,
              8'hFD, 104'h0},
             7, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst ready", data_in_ready, 1);
    chk("rst wr_valid", wr_valid, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst busy", busy, 0);
    chk("rst flags", {pkt_done, pkt_ok, err_timeout}, 0);

    for (int i = 0; i < 4; i++) run_vec(i);

    // Write stall: memory holds off the first word for 20 cycles
    clear_obs();
    wr_ready = 1'b0;
    for (int j = 0; j < 10; j++)
      send_byte(v[0].bytes[159 - 8*j -: 8]);
    data_in = 8'hEF;
    data_in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d wr", k), {wr_addr, wr_data},
          {32'h1000, 32'h12345678});
      chk($sformatf("stall%0d vr", k), {wr_valid, data_in_ready}, 2'b10);
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    for (int j = 10; j < 15; j++)
      send_byte(v[0].bytes[159 - 8*j -: 8]);
    check_pkt(0, "stall");

    // Silence after ADDR bytes: abort after 100 idle cycles
    clear_obs();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h10);
    begin
      int k = 0;
      while (n_tmo == 0 && k < 300) begin
        @(negedge clk);
        k++;
      end
    end
    repeat (5) @(negedge clk);
    chk("tmo pulses", n_tmo, 1);
    chk("tmo delay", tmo_cyc - last_acc, 101);
    chk("tmo busy", busy, 0);
    chk("tmo nwr", obs.size(), 0);
    chk("tmo done", n_done, 0);
    run_vec(0);

    // Reset while inside DATA drops the partial word
    clear_obs();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h78);
    send_byte(8'h56);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid busy", busy, 0);
    chk("mid wr_valid", wr_valid, 0);
    chk("mid ok", pkt_ok, 0);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'hEF);
    send_byte(8'hBE);
    repeat (3) @(negedge clk);
    chk("mid nwr", obs.size(), 0);
    chk("mid done", n_done, 0);
    chk("mid idle", {busy, wr_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
